// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: MM:SS BCD digits, 1 s tick prescaler,
// IDLE/RUN/PAUSE/DONE state machine with count-up and preset countdown.
module stopwatch_ctrl #(
   parameter int unsigned DIV = 50000000,
   parameter int unsigned CW  = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        load,
   input  logic        mode,
   input  logic [15:0] preset_d,
   output logic [15:0] digits,
   output logic        running,
   output logic        zero,
   output logic        done,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   localparam logic [CW-1:0] LP_TOP = CW'(DIV - 1);

   state_t         r_state;
   logic [15:0]    r_digits;
   logic [CW-1:0]  r_presc;
   logic           r_mode;
   logic           r_done;

   logic           w_tick;
   logic           w_zero;
   logic [15:0]    w_inc;
   logic [15:0]    w_dec;
   logic [15:0]    w_next;
   logic [15:0]    w_load_val;

   assign w_zero = (r_digits == '0);
   assign w_tick = (r_state == ST_RUN) && (r_presc == LP_TOP);
   assign w_next = r_mode ? w_dec : w_inc;

   always_comb begin
      w_inc = r_digits;
      if (r_digits[3:0] != 4'd9) w_inc[3:0] = r_digits[3:0] + 4'd1;
      else begin
         w_inc[3:0] = '0;
         if (r_digits[7:4] != 4'd5) w_inc[7:4] = r_digits[7:4] + 4'd1;
         else begin
            w_inc[7:4] = '0;
            if (r_digits[11:8] != 4'd9) w_inc[11:8] = r_digits[11:8] + 4'd1;
            else begin
               w_inc[11:8] = '0;
               w_inc[15:12] = (r_digits[15:12] != 4'd5) ? r_digits[15:12] + 4'd1 : '0;
            end
         end
      end
   end

   always_comb begin
      w_dec = r_digits;
      if (r_digits[3:0] != 4'd0) w_dec[3:0] = r_digits[3:0] - 4'd1;
      else begin
         w_dec[3:0] = 4'd9;
         if (r_digits[7:4] != 4'd0) w_dec[7:4] = r_digits[7:4] - 4'd1;
         else begin
            w_dec[7:4] = 4'd5;
            if (r_digits[11:8] != 4'd0) w_dec[11:8] = r_digits[11:8] - 4'd1;
            else begin
               w_dec[11:8] = 4'd9;
               w_dec[15:12] = (r_digits[15:12] != 4'd0) ? r_digits[15:12] - 4'd1 : 4'd5;
            end
         end
      end
   end

   always_comb begin
      w_load_val[15:12] = (preset_d[15:12] > 4'd5) ? 4'd5 : preset_d[15:12];
      w_load_val[11:8]  = (preset_d[11:8]  > 4'd9) ? 4'd9 : preset_d[11:8];
      w_load_val[7:4]   = (preset_d[7:4]   > 4'd5) ? 4'd5 : preset_d[7:4];
      w_load_val[3:0]   = (preset_d[3:0]   > 4'd9) ? 4'd9 : preset_d[3:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_digits <= '0;
         r_presc  <= '0;
         r_mode   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (clear) begin
            r_state  <= ST_IDLE;
            r_digits <= '0;
            r_presc  <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start_stop) begin
                     // a countdown from 00:00 has nothing to count, so stay idle
                     if (!(mode && w_zero)) begin
                        r_state <= ST_RUN;
                        r_mode  <= mode;
                        r_presc <= '0;
                     end
                  end else if (load) begin
                     r_digits <= w_load_val;
                     r_presc  <= '0;
                  end
               end
               ST_RUN: begin
                  r_presc <= w_tick ? '0 : r_presc + 1'b1;
                  if (w_tick) r_digits <= w_next;
                  // pause wins the state over a coincident tick; the digit update still lands
                  if (start_stop) r_state <= ST_PAUSE;
                  else if (w_tick && r_mode && (w_next == '0)) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
               ST_PAUSE: begin
                  if (start_stop) r_state <= ST_RUN;
                  else if (load) begin
                     r_digits <= w_load_val;
                     r_presc  <= '0;
                  end
               end
               ST_DONE: begin
                  if (start_stop) begin
                     r_state  <= ST_IDLE;
                     r_digits <= '0;
                     r_presc  <= '0;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign digits  = r_digits;
   assign done    = r_done;
   assign state   = r_state;
   assign zero    = w_zero;
   assign running = (r_state == ST_RUN);

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller for the stopwatch datapath. It owns the four BCD display digits (MM:SS) and an internal tick prescaler. It runs a run/pause/done state machine driven by debounced button pulses and supports count-up and preset countdown. It provides an all-digits-zero flag (4-digit NOR-style zero detect) and a countdown-complete pulse to the display and alarm logic.

Parameters:
DIV, 50000000, clock cycles per 1-second tick (minimum 2)
CW, 26, prescaler counter width (must satisfy 2^CW >= DIV)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_stop  input  1  one-cycle pulse, toggles run/pause
clear  input  1  one-cycle pulse, returns to IDLE with 00:00
load  input  1  one-cycle pulse, loads preset_d into digits
mode  input  1  0 = count up, 1 = count down
preset_d  input  16  BCD preset {m10[15:12], m1[11:8], s10[7:4], s1[3:0]}
digits  output  16  current BCD value, same packing as preset_d
running  output  1  high while in RUN
zero  output  1  high when all four digits = 0
done  output  1  one-cycle pulse when countdown reaches 00:00
state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, digits=0000, prescaler=0, mode latch=0, done=0, running=0. zero=1 follows from the digits.
- All state, digits, prescaler and done are registered. zero and running are combinational decodes of the digits and state.
- Mode latch: mode is sampled only on the IDLE->RUN transition. Changes to mode while in RUN or PAUSE have no effect.
- Prescaler: counts only in RUN. At DIV-1 it asserts an internal tick for one cycle and wraps to 0. It holds its value in PAUSE. It clears to 0 on clear, on entering IDLE, and on load.
- Digit update: digits change on the clock edge that ends the tick cycle (1-cycle latency from tick).
- Count up, s1 to m10: s1 0-9, s10 0-5, m1 0-9, m10 0-5, each stage carrying into the next. 59:59 + 1 wraps to 00:00 and the block stays in RUN.
- Count down: decrement with the same ranges, borrowing from the next stage. A tick at 00:01 sets digits=0000, state=DONE and done=1 on the same edge.
- Load: accepted in IDLE and PAUSE, ignored in RUN and DONE. Any tens digit >5 is clamped to 5 and any units digit >9 is clamped to 9.
- Transitions:
  - IDLE + start_stop -> RUN. Exception: if mode=1 and zero=1, the pulse is ignored and the block stays in IDLE.
  - RUN + start_stop -> PAUSE.
  - PAUSE + start_stop -> RUN, with the prescaler resuming from its held value.
  - DONE + start_stop -> IDLE, with digits held at 0000.
  - Any state + clear -> IDLE with digits=0000.
- Priority: clear > start_stop > load > tick.
  - start_stop coincident with a tick in RUN: the digit update is applied and the state goes to PAUSE on the same edge.
  - load coincident with start_stop in PAUSE: the state goes to RUN and the load is ignored.
- done: high exactly one cycle per countdown completion. It is never asserted in count-up mode.
- Reset asserted mid-operation aborts immediately to the reset values. No state survives.

Test Plan (DIV=4 unless noted):
1. Reset then start_stop with mode=0, run 10 ticks (40 cycles) -> digits=0x0010. running=1, zero=0. Each increment lands 1 cycle after the 4th prescaler count.
2. Load 0x5958 in IDLE, start with mode=0, 2 ticks -> 0x5959 then 0x0000. State stays RUN, done never pulses, zero=1 for the wrap interval.
3. Load 0x0100, mode=1, start, 60 ticks -> sequence 0059, 0058, ..., 0001, 0000. On the final edge: state=DONE, done=1 for exactly 1 cycle. Then start_stop -> IDLE with digits 0000.
4. Run up to 0x0003, start_stop 2 cycles into the prescaler period, wait 20 cycles, start_stop again -> digits hold 0x0003 during PAUSE. The next tick arrives 2 cycles after resume (prescaler held). Toggling mode during PAUSE does not change the count direction.
5. IDLE, digits 0000, mode=1, start_stop -> state stays IDLE. Load 0x7AF3 -> digits=0x5953 (clamped). Load pulse in RUN -> no change.
6. In RUN, assert clear and start_stop together -> IDLE with 0x0000. Separately, drop rst_n mid-count for 1 cycle, asynchronously between edges -> all outputs reach reset values before the next edge.
